// File: rtl/ksa_pkg.sv
// Shared constants and index helpers for the masked Kogge-Stone adder.
// Used by the gp init stage and later prefix stages.
package ksa_pkg;

    localparam int K_WIDTH_DEF  = 32;
    localparam int N_SHARES_DEF = 3;

    function automatic int rand_num(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Flat index of the fresh random word shared by share pair (i<j)
    function automatic int pair_idx(
        input int i,
        input int j,
        input int n
    );
        return i * n - i * (i + 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/ksa_gp_init_if.sv
// Shared bus bundle for the KSA gp init stage.
// Master drives operands and randomness, slave returns p/g.
interface ksa_gp_init_if
    import ksa_pkg::*;
#(
    parameter int K_WIDTH  = K_WIDTH_DEF,
    parameter int N_SHARES = N_SHARES_DEF
);

    localparam int MW = K_WIDTH * N_SHARES;
    localparam int RN = rand_num(N_SHARES);

    logic                  dvld;
    logic                  ena;
    logic [K_WIDTH*RN-1:0] rnd;
    logic [MW-1:0]         x;
    logic [MW-1:0]         y;
    logic [MW-1:0]         p;
    logic [MW-1:0]         g;
    logic                  ovld;

    modport master (
        output dvld, ena, rnd, x, y,
        input  p, g, ovld
    );

    modport slave (
        input  dvld, ena, rnd, x, y,
        output p, g, ovld
    );

endinterface

// File: rtl/ksa_dom_and.sv
// Generic N-share DOM-independent masked AND.
// Inner and cross terms are registered; compression follows the flops.
module ksa_dom_and
    import ksa_pkg::*;
#(
    parameter int K_WIDTH  = K_WIDTH_DEF,
    parameter int N_SHARES = N_SHARES_DEF,
    localparam int MW = K_WIDTH * N_SHARES,
    localparam int RN = rand_num(N_SHARES),
    localparam int NC = 2 * RN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [MW-1:0]         x,
    input  logic [MW-1:0]         y,
    input  logic [K_WIDTH*RN-1:0] rnd,
    output logic [MW-1:0]         z
);

    logic [K_WIDTH-1:0] inner_q [N_SHARES];
    logic [K_WIDTH-1:0] inner_d [N_SHARES];
    // Pair k stores x_i&y_j at 2k and x_j&y_i at 2k+1
    logic [K_WIDTH-1:0] cross_q [NC];
    logic [K_WIDTH-1:0] cross_d [NC];
    logic [MW-1:0]      z_c;

    always_comb begin
        inner_d = inner_q;
        cross_d = cross_q;
        if (en) begin
            for (int i = 0; i < N_SHARES; i++) begin
                inner_d[i] = x[i*K_WIDTH +: K_WIDTH]
                           & y[i*K_WIDTH +: K_WIDTH];
            end
            for (int i = 0; i < N_SHARES; i++) begin
                for (int j = i + 1; j < N_SHARES; j++) begin
                    cross_d[2*pair_idx(i, j, N_SHARES)] =
                        (x[i*K_WIDTH +: K_WIDTH]
                       & y[j*K_WIDTH +: K_WIDTH])
                       ^ rnd[pair_idx(i, j, N_SHARES)*K_WIDTH
                             +: K_WIDTH];
                    cross_d[2*pair_idx(i, j, N_SHARES)+1] =
                        (x[j*K_WIDTH +: K_WIDTH]
                       & y[i*K_WIDTH +: K_WIDTH])
                       ^ rnd[pair_idx(i, j, N_SHARES)*K_WIDTH
                             +: K_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SHARES; i++) begin
                inner_q[i] <= '0;
            end
            for (int c = 0; c < NC; c++) begin
                cross_q[c] <= '0;
            end
        end else begin
            inner_q <= inner_d;
            cross_q <= cross_d;
        end
    end

    always_comb begin
        z_c = '0;
        for (int i = 0; i < N_SHARES; i++) begin
            z_c[i*K_WIDTH +: K_WIDTH] = inner_q[i];
            for (int j = 0; j < N_SHARES; j++) begin
                if (j > i) begin
                    z_c[i*K_WIDTH +: K_WIDTH] ^=
                        cross_q[2*pair_idx(i, j, N_SHARES)];
                end else if (j < i) begin
                    z_c[i*K_WIDTH +: K_WIDTH] ^=
                        cross_q[2*pair_idx(j, i, N_SHARES)+1];
                end
            end
        end
    end

    assign z = z_c;

endmodule

// File: rtl/ksa_gp_init.sv
// Masked KSA first stage: registered share-wise p = x ^ y
// and DOM-independent g = x & y, both valid-tagged.
module ksa_gp_init
    import ksa_pkg::*;
#(
    parameter int K_WIDTH   = K_WIDTH_DEF,
    parameter int N_SHARES  = N_SHARES_DEF,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int RANDNUM   = rand_num(N_SHARES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dvld,
    input  logic                       ena,
    input  logic [K_WIDTH*RANDNUM-1:0] rnd,
    input  logic [MASKWIDTH-1:0]       i_x,
    input  logic [MASKWIDTH-1:0]       i_y,
    output logic [MASKWIDTH-1:0]       o_p,
    output logic [MASKWIDTH-1:0]       o_g,
    output logic                       ovld
);

    logic                 load;
    logic [MASKWIDTH-1:0] p_q;
    logic [MASKWIDTH-1:0] p_d;
    logic                 vld_q;
    logic                 vld_d;

    assign load = ena & dvld;

    always_comb begin
        p_d   = p_q;
        vld_d = vld_q;
        if (load) begin
            p_d = i_x ^ i_y;
        end
        if (ena) begin
            vld_d = dvld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            vld_q <= vld_d;
        end
    end

    ksa_dom_and #(
        .K_WIDTH  (K_WIDTH),
        .N_SHARES (N_SHARES)
    ) u_g_and (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .x     (i_x),
        .y     (i_y),
        .rnd   (rnd),
        .z     (o_g)
    );

    assign o_p  = p_q;
    assign ovld = vld_q;

endmodule

// File: tb/tb_ksa_gp_init.sv
// Directed bench for ksa_gp_init: 2-share/8-bit and
// 3-share/32-bit instances checked against unmasked values.
module tb_ksa_gp_init;
    import ksa_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ksa_gp_init_if #(.K_WIDTH(8), .N_SHARES(2)) b2 ();
    ksa_gp_init_if b3 ();

    ksa_gp_init #(.K_WIDTH(8), .N_SHARES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .dvld  (b2.dvld),
        .ena   (b2.ena),
        .rnd   (b2.rnd),
        .i_x   (b2.x),
        .i_y   (b2.y),
        .o_p   (b2.p),
        .o_g   (b2.g),
        .ovld  (b2.ovld)
    );

    ksa_gp_init dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .dvld  (b3.dvld),
        .ena   (b3.ena),
        .rnd   (b3.rnd),
        .i_x   (b3.x),
        .i_y   (b3.y),
        .o_p   (b3.p),
        .o_g   (b3.g),
        .ovld  (b3.ovld)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] um3(input logic [95:0] v);
        return v[31:0] ^ v[63:32] ^ v[95:64];
    endfunction

    function automatic logic [31:0] um2(input logic [15:0] v);
        return {24'h0, v[7:0] ^ v[15:8]};
    endfunction

    logic [31:0] ex_p;
    logic [31:0] ex_g;
    logic [31:0] ax;
    logic [31:0] ay;

    task automatic drive3(input logic dv);
        b3.x    = {$urandom, $urandom, $urandom};
        b3.y    = {$urandom, $urandom, $urandom};
        b3.rnd  = {$urandom, $urandom, $urandom};
        b3.dvld = dv;
        ax = um3(b3.x);
        ay = um3(b3.y);
    endtask

    task automatic chk3(input string tag, input logic v);
        check({tag, "_vld"}, {31'h0, b3.ovld}, {31'h0, v});
        check({tag, "_p"}, um3(b3.p), ex_p);
        check({tag, "_g"}, um3(b3.g), ex_g);
    endtask

    initial begin
        rst_n   = 1'b1;
        b2.dvld = 1'b0;
        b2.ena  = 1'b0;
        b2.rnd  = '0;
        b2.x    = '0;
        b2.y    = '0;
        b3.dvld = 1'b0;
        b3.ena  = 1'b0;
        b3.rnd  = '0;
        b3.x    = '0;
        b3.y    = '0;
        #1 rst_n = 1'b0;
        #11;
        check("rst_p3", {31'h0, |b3.p}, 32'h0);
        check("rst_g3", {31'h0, |b3.g}, 32'h0);
        check("rst_v3", {31'h0, b3.ovld}, 32'h0);
        check("rst_v2", {31'h0, b2.ovld}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, 2 shares: x=0x5A, y=0x33, rnd=0
        @(negedge clk);
        b2.x    = {8'h55, 8'h0F};
        b2.y    = {8'h00, 8'h33};
        b2.rnd  = 8'h00;
        b2.dvld = 1'b1;
        b2.ena  = 1'b1;
        @(negedge clk);
        check("basic_vld", {31'h0, b2.ovld}, 32'h1);
        check("basic_p", um2(b2.p), 32'h69);
        check("basic_g", um2(b2.g), 32'h12);
        check("basic_g0", {24'h0, b2.g[7:0]}, 32'h03);
        check("basic_g1", {24'h0, b2.g[15:8]}, 32'h11);
        b2.rnd = 8'hA7;
        @(negedge clk);
        check("rnd_vld", {31'h0, b2.ovld}, 32'h1);
        check("rnd_p", um2(b2.p), 32'h69);
        check("rnd_g", um2(b2.g), 32'h12);
        check("rnd_g0", {24'h0, b2.g[7:0]}, 32'hA4);
        check("rnd_g1", {24'h0, b2.g[15:8]}, 32'hB6);
        b2.dvld = 1'b0;
        @(negedge clk);
        check("basic_drop", {31'h0, b2.ovld}, 32'h0);

        // Stream, 3 shares, back-to-back
        b3.ena = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin
                chk3("stream", 1'b1);
            end
            drive3(1'b1);
            @(negedge clk);
            ex_p = ax ^ ay;
            ex_g = ax & ay;
        end
        chk3("stream_last", 1'b1);

        // Stall with changing inputs
        b3.ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive3(1'($urandom_range(1)));
            @(negedge clk);
            chk3("stall", 1'b1);
        end
        b3.ena = 1'b1;
        drive3(1'b1);
        @(negedge clk);
        ex_p = ax ^ ay;
        ex_g = ax & ay;
        chk3("unstall", 1'b1);

        // Gaps: dvld 1,0,0,1
        drive3(1'b1);
        @(negedge clk);
        ex_p = ax ^ ay;
        ex_g = ax & ay;
        chk3("gap0", 1'b1);
        drive3(1'b0);
        @(negedge clk);
        chk3("gap1", 1'b0);
        drive3(1'b0);
        @(negedge clk);
        chk3("gap2", 1'b0);
        drive3(1'b1);
        @(negedge clk);
        ex_p = ax ^ ay;
        ex_g = ax & ay;
        chk3("gap3", 1'b1);

        // Asynchronous reset between edges, mid-stream
        drive3(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_p", {31'h0, |b3.p}, 32'h0);
        check("arst_g", {31'h0, |b3.g}, 32'h0);
        check("arst_v", {31'h0, b3.ovld}, 32'h0);
        @(negedge clk);
        check("arst_hold_v", {31'h0, b3.ovld}, 32'h0);
        check("arst_hold_p", {31'h0, |b3.p}, 32'h0);
        rst_n = 1'b1;
        drive3(1'b0);
        @(negedge clk);
        check("post_idle_v", {31'h0, b3.ovld}, 32'h0);
        check("post_idle_p", {31'h0, |b3.p}, 32'h0);
        drive3(1'b1);
        @(negedge clk);
        ex_p = ax ^ ay;
        ex_g = ax & ay;
        chk3("post_first", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
